// File: rtl/booth_seq_divider_16x8_pkg.sv
// Shared definitions for the sequential signed divider: default widths and FSM state encoding.
package booth_seq_divider_16x8_pkg;

  localparam int DIV_DW = 16;
  localparam int DIV_VW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/booth_seq_divider_16x8_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract |D|.
module div_restore_step #(
  parameter int VW = 8
) (
  input  logic [VW:0] i_rem,
  input  logic        i_bit,
  input  logic [VW:0] i_dmag,
  output logic [VW:0] o_rem,
  output logic        o_qbit
);

  logic [VW+1:0] w_shifted;
  logic [VW+1:0] w_dmag_ext;
  logic          w_ge;

  assign w_shifted  = {i_rem, i_bit};
  assign w_dmag_ext = {1'b0, i_dmag};
  assign w_ge       = (w_shifted >= w_dmag_ext);

  // A kept difference is always below |D|, so it fits back into VW+1 bits.
  assign o_qbit = w_ge;
  assign o_rem  = w_ge ? (VW+1)'(w_shifted - w_dmag_ext) : w_shifted[VW:0];

endmodule

// File: rtl/booth_seq_divider_16x8.sv
// Sequential signed restoring divider (DW-bit dividend / VW-bit divisor), one quotient bit
// per clock plus a sign-fix cycle. Optional macro DIV_ZERO_FAST_EN short-cuts D==0.
module booth_seq_divider_16x8
  import booth_seq_divider_16x8_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] N,
  input  logic signed [VW-1:0] D,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] Q,
  output logic signed [VW-1:0] R,
  output logic                 dbz
);

  localparam int CW = $clog2(DW + 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_nq;
  logic [VW:0]   r_rem;
  logic [VW:0]   r_dmag;
  logic [VW-1:0] r_n_low;
  logic [CW-1:0] r_cnt;
  logic          r_sign_q;
  logic          r_sign_r;
  logic          r_dbz_pend;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_r;
  logic          r_dbz;
  logic          r_out_valid;

  logic [DW-1:0] w_n_mag;
  logic [VW:0]   w_d_ext;
  logic [VW:0]   w_d_mag;
  logic          w_d_zero;
  logic [VW:0]   w_rem_next;
  logic          w_qbit;
  logic [VW-1:0] w_rmag;

  // |-2^(DW-1)| is 2^(DW-1), which is exact as an unsigned DW-bit value.
  assign w_n_mag  = N[DW-1] ? -N : N;
  assign w_d_ext  = {D[VW-1], D};
  assign w_d_mag  = D[VW-1] ? -w_d_ext : w_d_ext;
  assign w_d_zero = (D == '0);
  assign w_rmag   = r_rem[VW-1:0];

  div_restore_step #(
    .VW (VW)
  ) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_nq[DW-1]),
    .i_dmag (r_dmag),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef DIV_ZERO_FAST_EN
          w_state_next = w_d_zero ? ST_FIX : ST_CALC;
`else
          w_state_next = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        if (r_cnt == CW'(1)) begin
          w_state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        if (r_cnt == '0) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nq        <= '0;
      r_rem       <= '0;
      r_dmag      <= '0;
      r_n_low     <= '0;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dbz_pend  <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_nq       <= w_n_mag;
            r_rem      <= '0;
            r_dmag     <= w_d_mag;
            r_n_low    <= N[VW-1:0];
            r_sign_q   <= N[DW-1] ^ D[VW-1];
            r_sign_r   <= N[DW-1];
            r_dbz_pend <= w_d_zero;
`ifdef DIV_ZERO_FAST_EN
            // A residual count of 1 makes FIX wait one edge, giving a 2-edge latency.
            r_cnt      <= w_d_zero ? CW'(1) : CW'(DW);
`else
            r_cnt      <= CW'(DW);
`endif
          end
        end
        ST_CALC: begin
          // r_nq shifts dividend bits out at the top and quotient bits in at the bottom.
          r_nq  <= {r_nq[DW-2:0], w_qbit};
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - CW'(1);
        end
        ST_FIX: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_out_valid <= 1'b1;
            r_dbz       <= r_dbz_pend;
            if (r_dbz_pend) begin
              r_q <= '1;
              r_r <= r_n_low;
            end else begin
              r_q <= r_sign_q ? -r_nq : r_nq;
              r_r <= r_sign_r ? -w_rmag : w_rmag;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign Q         = r_q;
  assign R         = r_r;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_booth_seq_divider_16x8.sv
// Self-checking bench for booth_seq_divider_16x8: directed corners plus random operands.
module tb_booth_seq_divider_16x8;

  localparam int DW  = 16;
  localparam int VW  = 8;
  localparam int LAT = DW + 1;
`ifdef DIV_ZERO_FAST_EN
  localparam int LAT_DBZ = 2;
`else
  localparam int LAT_DBZ = DW + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] N;
  logic [VW-1:0] D;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] Q;
  logic [VW-1:0] R;
  logic          dbz;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] n;
    logic [VW-1:0] d;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  booth_seq_divider_16x8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .N         (N),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .dbz       (dbz)
  );

  // Reference: integer division truncating toward zero, remainder takes N's sign.
  function automatic exp_t model(input logic [DW-1:0] n, input logic [VW-1:0] d);
    exp_t e;
    int   ni;
    int   di;
    ni  = int'($signed(n));
    di  = int'($signed(d));
    e.n = n;
    e.d = d;
    if (di == 0) begin
      e.q = '1;
      e.r = n[VW-1:0];
      e.z = 1'b1;
    end else begin
      e.q = 16'(ni / di);
      e.r = 8'(ni % di);
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compare process: while out_valid is up the outputs must match the head expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("Q", 32'(Q), 32'(exp_q[0].q));
        chk("R", 32'(R), 32'(exp_q[0].r));
        chk("dbz", 32'(dbz), 32'(exp_q[0].z));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (out_ready) begin
          $display("txn N=%0d D=%0d Q=%0d R=%0d dbz=%0b", $signed(exp_q[0].n),
                   $signed(exp_q[0].d), $signed(Q), $signed(R), dbz);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic run(input logic [DW-1:0] n, input logic [VW-1:0] d, input bit lit,
                     input logic [DW-1:0] lq, input logic [VW-1:0] lr, input logic lz,
                     input int hold);
    exp_t e;
    int   cyc;
    e = model(n, d);
    if (lit) begin
      chk("model_q", 32'(e.q), 32'(lq));
      chk("model_r", 32'(e.r), 32'(lr));
      chk("model_dbz", 32'(e.z), 32'(lz));
      e.q = lq;
      e.r = lr;
      e.z = lz;
    end
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    N        = n;
    D        = d;
    in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), e.z ? 32'(LAT_DBZ) : 32'(LAT));
    if (!out_valid) exp_q.delete();
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      N        = 16'($urandom);
      @(posedge clk); #1;
      chk("in_ready_held", 32'(in_ready), 32'd0);
      chk("out_valid_held", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_pop", 32'(in_ready), 32'd1);
    chk("out_valid_clear", 32'(out_valid), 32'd0);
  endtask

  logic [DW-1:0] t_n [7] = '{16'hFFF1, 16'd84, 16'hC080, 16'd7, 16'hFFF9, 16'h8000, 16'd100};
  logic [VW-1:0] t_d [7] = '{8'hFD, 8'hF9, 8'h80, 8'hFE, 8'd2, 8'hFF, 8'd0};
  logic [DW-1:0] t_q [7] = '{16'd5, 16'hFFF4, 16'd127, 16'hFFFD, 16'hFFFD, 16'h8000, 16'hFFFF};
  logic [VW-1:0] t_r [7] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'hFF, 8'd0, 8'h64};
  logic          t_z [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    N         = '0;
    D         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_Q", 32'(Q), 32'd0);
    chk("reset_R", 32'(R), 32'd0);
    chk("reset_dbz", 32'(dbz), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run(t_n[i], t_d[i], 1'b1, t_q[i], t_r[i], t_z[i], 0);
    end

    // Backpressure: 1000 / 7 = 142 r 6, result held for 5 cycles.
    run(16'd1000, 8'd7, 1'b1, 16'd142, 8'd6, 1'b0, 5);

    // Reset during CALC discards the operation.
    N        = 16'h1234;
    D        = 8'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_Q", 32'(Q), 32'd0);
    chk("midrst_R", 32'(R), 32'd0);
    chk("midrst_dbz", 32'(dbz), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    run(16'd127, 8'd1, 1'b1, 16'd127, 8'd0, 1'b0, 0);

    for (int i = 0; i < 1000; i++) begin
      logic [DW-1:0] rn;
      logic [VW-1:0] rd;
      rn = 16'($urandom);
      rd = 8'($urandom);
      if (rd == '0) rd = 8'($urandom_range(1, 255));
      run(rn, rd, 1'b0, '0, '0, 1'b0, (i % 50 == 0) ? 2 : 0);
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
